pipeline_hazard_ctrl: RTL

- Pipeline sequencing controller for the RV32I core. Sits beside the EX-stage operand forwarding unit.
- Resolves the hazards that forwarding cannot cover:
  - load-use stalls (bubble insertion)
  - taken-branch redirect and flush
  - data-memory wait freeze, with timeout detection
- Drives the stall, flush and bubble enables of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : RV32I hazard sequencer - load-use bubbles, branch flush/redirect,
//             data-memory wait freeze with timeout, stall/flush counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic [31:0]      branch_target_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             stall_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [1:0]        LU_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              ret_lu_q, ret_lu_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic lu;
    logic mw;

    assign lu = mem_read_ex && (rd_ex != 5'd0) &&
                ((rs1_used_id && (rs1_id == rd_ex)) ||
                 (rs2_used_id && (rs2_id == rd_ex)));
    assign mw = dmem_req_mem && !dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            ret_lu_q    <= 1'b0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ret_lu_q    <= ret_lu_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ret_lu_d   = ret_lu_q;
        case (state_q)
            ST_RUN: begin
                if (mw) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                    ret_lu_d   = 1'b0;
                end else if (!branch_taken_ex && lu && (LOAD_STALL_CYCLES > 1)) begin
                    state_d  = ST_LU_STALL;
                    lu_cnt_d = LU_RELOAD;
                end
            end
            ST_LU_STALL: begin
                // The remaining bubble count is frozen across a memory wait
                if (mw) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                    ret_lu_d   = 1'b1;
                end else begin
                    lu_cnt_d = lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mw) begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d = ret_lu_q ? ST_LU_STALL : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        stall_ex    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        pc_redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mw) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else if (branch_taken_ex) begin
                    pc_redirect = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (lu) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            ST_LU_STALL: begin
                if (mw) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mw) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end
            end
            default: ;
        endcase
        // Inputs may still show a hazard while reset is held; keep outputs quiet
        if (!rst_n) begin
            stall_if    = 1'b0;
            stall_id    = 1'b0;
            bubble_ex   = 1'b0;
            stall_ex    = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
            pc_redirect = 1'b0;
        end
    end

    always_comb begin
        timeout_d   = timeout_q | ((state_d == ST_MEM_WAIT) && (wait_cnt_d >= WAIT_MAX));
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_if && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (pc_redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign pc_target    = pc_redirect ? branch_target_ex : 32'd0;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

`default_nettype wire
